// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter sharing one slave port among NM masters.
// An owner is picked in IDLE and registered, so arbitration takes one cycle. The owner keeps
// the slave until it drops cyc. A watchdog ends strobes that the slave never terminates.
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // master side, master i packed at [i*W +: W]
    input  logic [NM*AW-1:0]  wbm_adr_i,
    input  logic [NM*DW-1:0]  wbm_dat_i,
    input  logic [NM*DW/8-1:0] wbm_sel_i,
    input  logic [NM-1:0]     wbm_we_i,
    input  logic [NM-1:0]     wbm_cyc_i,
    input  logic [NM-1:0]     wbm_stb_i,
    input  logic [NM*3-1:0]   wbm_cti_i,
    input  logic [NM*2-1:0]   wbm_bte_i,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [NM-1:0]     wbm_ack_o,
    output logic [NM-1:0]     wbm_err_o,
    output logic [NM-1:0]     wbm_rty_o,
    // slave side
    output logic [AW-1:0]     wbs_adr_o,
    output logic [DW-1:0]     wbs_dat_o,
    output logic [DW/8-1:0]   wbs_sel_o,
    output logic              wbs_we_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic [2:0]        wbs_cti_o,
    output logic [1:0]        wbs_bte_o,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i,
    input  logic              wbs_rty_i,
    // arbitration status
    output logic [NM-1:0]     grant_o
);

    localparam int IW  = $clog2(NM);
    localparam int SW  = DW / 8;
    // 8 bits cover the default limit; larger limits get a 16-bit counter
    localparam int WDW = (TIMEOUT > 255) ? 16 : 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic            found;
    logic [IW-1:0]   win;
    logic            busy;
    logic            g_cyc, g_stb, g_we;
    logic            term;
    logic            tmo;

    assign busy  = (state_q == BUSY);
    assign g_cyc = wbm_cyc_i[own_q];
    assign g_stb = wbm_stb_i[own_q];
    assign g_we  = wbm_we_i[own_q];
    assign term  = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // A slave termination in the limit cycle takes priority over the timeout error
    assign tmo = (TIMEOUT != 0) && busy && g_cyc && g_stb && !term
                 && (wd_q == WDW'(TIMEOUT));

    // Round-robin search: start one past the last winner and wrap; first cyc wins
    always_comb begin
        int idx;
        found = 1'b0;
        win   = last_q;
        idx   = 0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last_q) + k) % NM;
            if (!found && wbm_cyc_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Next-state logic: grant on any request in IDLE, release when the owner drops cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (found) begin
                    state_d = BUSY;
                    own_d   = win;
                    last_d  = win;
                    grant_d = {{(NM-1){1'b0}}, 1'b1} << win;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    wd_d    = '0;
                end else if (term || !g_stb || tmo) begin
                    wd_d = '0;
                end else if (TIMEOUT != 0) begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer and watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Request pass-through and response routing; reset silences the bus immediately
    always_comb begin
        wbs_adr_o = wbm_adr_i[int'(own_q)*AW +: AW];
        wbs_dat_o = wbm_dat_i[int'(own_q)*DW +: DW];
        wbs_sel_o = wbm_sel_i[int'(own_q)*SW +: SW];
        wbs_cti_o = wbm_cti_i[int'(own_q)*3 +: 3];
        wbs_bte_o = wbm_bte_i[int'(own_q)*2 +: 2];
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (busy && !rst) begin
            wbs_we_o  = g_we;
            wbs_cyc_o = g_cyc;
            wbs_stb_o = g_stb && !tmo;
            wbm_ack_o = grant_q & {NM{wbs_ack_i}};
            wbm_err_o = grant_q & {NM{wbs_err_i | tmo}};
            wbm_rty_o = grant_q & {NM{wbs_rty_i}};
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed checks of wb_rr_arbiter with three masters and a short watchdog.
module tb_wb_rr_arbiter;

    localparam int NM = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [DW-1:0]     wbm_dat_o;
    logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]        wbs_cti_o;
    logic [1:0]        wbs_bte_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err, s_rty;
    logic [NM-1:0]     grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_rr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
        .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
        .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    // sample point for the current cycle
    task automatic nb();
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        tk(); tk();
        nb();
        check("rst_grant", 64'(grant_o), 0);
        check("rst_cyc", 64'(wbs_cyc_o), 0);
        check("rst_stb", 64'(wbs_stb_o), 0);
        tk();
        rst = 1'b0;

        // single master, slave acks in cycle 3
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0 +: AW] = 32'h100; m_dat[0 +: DW] = 32'hA5A5_0001;
        nb();
        check("t1_idle_grant", 64'(grant_o), 0);
        check("t1_idle_cyc", 64'(wbs_cyc_o), 0);
        tk();
        nb();
        check("t1_grant", 64'(grant_o), 'b001);
        check("t1_cyc", 64'(wbs_cyc_o), 1);
        check("t1_stb", 64'(wbs_stb_o), 1);
        check("t1_adr", 64'(wbs_adr_o), 'h100);
        check("t1_dat", 64'(wbs_dat_o), 'hA5A5_0001);
        check("t1_we", 64'(wbs_we_o), 1);
        check("t1_noack", 64'(wbm_ack_o), 0);
        tk();
        nb();
        check("t1_noack2", 64'(wbm_ack_o), 0);
        tk();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        nb();
        check("t1_ack", 64'(wbm_ack_o), 'b001);
        check("t1_rdat", 64'(wbm_dat_o), 'hDEAD_BEEF);
        tk();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_we[0] = 1'b0;
        nb();
        check("t1_drop_cyc", 64'(wbs_cyc_o), 0);
        check("t1_drop_grant", 64'(grant_o), 'b001);
        tk();
        nb();
        check("t1_idle_after", 64'(grant_o), 0);
        check("t1_idle_we", 64'(wbs_we_o), 0);
        tk();

        // contention between m0 and m1; last winner was m0 so m1 goes first
        m_adr[0 +: AW] = 32'h200; m_adr[AW +: AW] = 32'h300;
        m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
        nb();
        check("t2_idle0", 64'(grant_o), 0);
        tk();
        s_ack = 1'b1;
        nb();
        check("t2_grant_m1", 64'(grant_o), 'b010);
        check("t2_adr_m1", 64'(wbs_adr_o), 'h300);
        check("t2_ack_m1", 64'(wbm_ack_o), 'b010);
        tk();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        nb();
        check("t2_m1_release", 64'(wbs_cyc_o), 0);
        tk();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        nb();
        check("t2_idle1", 64'(grant_o), 0);
        tk();
        s_ack = 1'b1;
        nb();
        check("t2_grant_m0", 64'(grant_o), 'b001);
        check("t2_adr_m0", 64'(wbs_adr_o), 'h200);
        check("t2_ack_m0", 64'(wbm_ack_o), 'b001);
        tk();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        nb();
        tk();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        nb();
        check("t2_idle2", 64'(grant_o), 0);
        tk();
        // ack and cyc fall together
        s_ack = 1'b1; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        nb();
        check("t2_grant_m1b", 64'(grant_o), 'b010);
        check("t2_ack_on_fall", 64'(wbm_ack_o), 'b010);
        check("t2_cyc_on_fall", 64'(wbs_cyc_o), 0);
        tk();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        nb();
        check("t2_idle_after_fall", 64'(grant_o), 0);
        tk();

        // burst by m1 while m0 waits
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[3 +: 3] = 3'b010;
        nb();
        tk();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_ack = 1'b1;
            nb();
            check("t3_burst_grant", 64'(grant_o), 'b010);
            check("t3_burst_ack", 64'(wbm_ack_o), 'b010);
            check("t3_burst_cti", 64'(wbs_cti_o), 'b010);
            tk();
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cti = '0;
        nb();
        check("t3_release_grant", 64'(grant_o), 'b010);
        check("t3_release_cyc", 64'(wbs_cyc_o), 0);
        tk();
        nb();
        check("t3_gap", 64'(grant_o), 0);
        tk();
        nb();
        check("t3_m0_grant", 64'(grant_o), 'b001);
        check("t3_m0_adr", 64'(wbs_adr_o), 'h200);
        tk();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        nb();
        tk();

        // watchdog: m2 strobes, slave silent
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; m_adr[2*AW +: AW] = 32'h3C;
        nb();
        tk();
        for (int i = 0; i < TO; i++) begin
            nb();
            check("t4_stall_err", 64'(wbm_err_o), 0);
            check("t4_stall_stb", 64'(wbs_stb_o), 1);
            tk();
        end
        nb();
        check("t4_tmo_err", 64'(wbm_err_o), 'b100);
        check("t4_tmo_stb", 64'(wbs_stb_o), 0);
        check("t4_tmo_grant", 64'(grant_o), 'b100);
        tk();
        for (int i = 0; i < TO; i++) begin
            nb();
            check("t4_restall_err", 64'(wbm_err_o), 0);
            tk();
        end
        // termination coincides with limit: ack wins, no error
        s_ack = 1'b1;
        nb();
        check("t4_race_ack", 64'(wbm_ack_o), 'b100);
        check("t4_race_err", 64'(wbm_err_o), 0);
        tk();
        s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
        nb();
        tk();

        // reset in the middle of an m0 burst
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[0 +: 3] = 3'b010;
        nb();
        tk();
        for (int b = 0; b < 2; b++) begin
            s_ack = 1'b1;
            nb();
            check("t5_pre_ack", 64'(wbm_ack_o), 'b001);
            tk();
        end
        rst = 1'b1;
        nb();
        check("t5_rst_cyc", 64'(wbs_cyc_o), 0);
        check("t5_rst_stb", 64'(wbs_stb_o), 0);
        check("t5_rst_ack", 64'(wbm_ack_o), 0);
        tk();
        s_ack = 1'b0;
        nb();
        check("t5_rst_grant", 64'(grant_o), 0);
        tk();
        rst = 1'b0; m_cyc = 3'b111; m_stb = 3'b111; m_cti = '0;
        nb();
        check("t5_idle", 64'(grant_o), 0);
        tk();
        nb();
        check("t5_first_m0", 64'(grant_o), 'b001);
        tk();
        m_cyc = '0; m_stb = '0;
        tk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
